// File: rtl/cic_cfg_sequencer_pkg.sv
// Shared types for the CIC runtime-config sequencer: FSM states, error codes, word indices.
// Pure declarations, no logic.
package cic_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SEND,
        WAIT_DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

    localparam logic [1:0] IDX_NUMSECS = 2'd0;
    localparam logic [1:0] IDX_DCEF    = 2'd1;
    localparam logic [1:0] IDX_SCALE   = 2'd2;

endpackage

// File: rtl/cic_cfg_sequencer_if.sv
// Host request/status, sample-gate and CIC word-serial config signals of the sequencer.
// slave = sequencer side, master = host / source / CIC side.
interface cic_cfg_sequencer_if #(
    parameter int DW = 16
);
    logic          Cfg_Req;
    logic [DW-1:0] Cfg_NumSecs;
    logic [DW-1:0] Cfg_Dcef;
    logic [DW-1:0] Cfg_Scale;
    logic          Cfg_Busy;
    logic          Cfg_Done;
    logic [1:0]    Cfg_Err;
    logic          Src_Valid;
    logic          Gated_Valid;
    logic [15:0]   Drop_Cnt;
    logic          isConfig;
    logic [DW-1:0] Data_Config_Out;
    logic          isConfigACK;
    logic          isConfigDone;

    modport slave (
        input  Cfg_Req, Cfg_NumSecs, Cfg_Dcef, Cfg_Scale, Src_Valid, isConfigACK, isConfigDone,
        output Cfg_Busy, Cfg_Done, Cfg_Err, Gated_Valid, Drop_Cnt, isConfig, Data_Config_Out
    );

    modport master (
        output Cfg_Req, Cfg_NumSecs, Cfg_Dcef, Cfg_Scale, Src_Valid, isConfigACK, isConfigDone,
        input  Cfg_Busy, Cfg_Done, Cfg_Err, Gated_Valid, Drop_Cnt, isConfig, Data_Config_Out
    );

endinterface

// File: rtl/cic_cfg_sequencer_timeout_cnt.sv
// Loadable down-counter; o_expire is high while the count sits at zero.
// Load has priority over decrement; the count holds at zero.
module cic_cfg_timeout_cnt #(
    parameter int W = 11
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/cic_cfg_sequencer.sv
// Gates the sample stream, drains the CIC, then streams NUMSECS/DCEF/SCALE over the ACK/Done handshake.
// Request to Done: 1 + DRAIN_CYCLES + ACK/Done latency of the CIC; requests while busy are dropped.
module cic_cfg_sequencer
    import cic_cfg_pkg::*;
#(
    parameter int CIC_CONFIG_DATA_WIDTH = 16,
    parameter int CIC_MAX_NUMSECS       = 16,
    parameter int CIC_MAX_DCEF          = 16,
    parameter int DRAIN_CYCLES          = 64,
    parameter int TIMEOUT_CYCLES        = 1024
) (
    input  logic CLK,
    input  logic RST,
    cic_cfg_sequencer_if.slave bus
);

    localparam int DW      = CIC_CONFIG_DATA_WIDTH;
    localparam int CNT_MAX = (DRAIN_CYCLES > TIMEOUT_CYCLES) ? DRAIN_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_numsecs;
    logic [DW-1:0] r_dcef;
    logic [DW-1:0] r_scale;
    logic [1:0]    r_idx;
    err_t          r_err;
    logic          r_done;
    logic [15:0]   r_drop;

    logic             w_accept;
    logic             w_range_ok;
    logic             w_gate_en;
    logic             w_cfg_active;
    logic             w_idx_inc;
    logic             w_done_set;
    logic             w_err_set;
    err_t             w_err_code;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tmr_exp;
    logic [DW-1:0]    w_word;

    assign w_accept   = (r_state == IDLE) && bus.Cfg_Req;
    assign w_range_ok = (bus.Cfg_NumSecs != '0) && (bus.Cfg_NumSecs <= DW'(CIC_MAX_NUMSECS)) &&
                        (bus.Cfg_Dcef    != '0) && (bus.Cfg_Dcef    <= DW'(CIC_MAX_DCEF));

    assign w_cfg_active = (r_state == SEND) || (r_state == WAIT_DONE);
    assign w_gate_en    = !((r_state == DRAIN) || w_cfg_active);
    assign w_tmr_en     = !w_gate_en;

    // One counter serves both the drain window and the SEND/WAIT_DONE watchdog.
    cic_cfg_timeout_cnt #(.W(CNT_W)) u_tmr (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_expire   (w_tmr_exp)
    );

    always_comb begin
        w_next     = r_state;
        w_idx_inc  = 1'b0;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        w_err_code = ERR_NONE;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            IDLE: begin
                if (bus.Cfg_Req) begin
                    w_err_set = 1'b1;
                    if (w_range_ok) begin
                        w_next     = DRAIN;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = CNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        w_next     = ERR;
                        w_err_code = ERR_RANGE;
                    end
                end
            end
            DRAIN: begin
                if (w_tmr_exp) begin
                    w_next     = SEND;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(TIMEOUT_CYCLES - 1);
                end
            end
            SEND: begin
                // Done before the last word was acknowledged is a CIC protocol violation.
                if (bus.isConfigDone || w_tmr_exp) begin
                    w_next     = ERR;
                    w_err_set  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end else if (bus.isConfigACK) begin
                    if (r_idx == IDX_SCALE) begin
                        w_next = WAIT_DONE;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.isConfigDone) begin
                    w_next     = IDLE;
                    w_done_set = 1'b1;
                end else if (w_tmr_exp) begin
                    w_next     = ERR;
                    w_err_set  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_numsecs <= '0;
            r_dcef    <= '0;
            r_scale   <= '0;
            r_idx     <= IDX_NUMSECS;
            r_err     <= ERR_NONE;
            r_done    <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_set;
            if (w_err_set) begin
                r_err <= w_err_code;
            end
            if (w_accept) begin
                r_numsecs <= bus.Cfg_NumSecs;
                r_dcef    <= bus.Cfg_Dcef;
                r_scale   <= bus.Cfg_Scale;
                r_idx     <= IDX_NUMSECS;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_accept) begin
                r_drop <= '0;
            end else if (bus.Src_Valid && !w_gate_en && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_comb begin
        w_word = '0;
        if (w_cfg_active) begin
            case (r_idx)
                IDX_NUMSECS: w_word = r_numsecs;
                IDX_DCEF:    w_word = r_dcef;
                default:     w_word = r_scale;
            endcase
        end
    end

    assign bus.Gated_Valid     = bus.Src_Valid && w_gate_en;
    assign bus.Cfg_Busy        = (r_state != IDLE);
    assign bus.Cfg_Done        = r_done;
    assign bus.Cfg_Err         = r_err;
    assign bus.Drop_Cnt        = r_drop;
    assign bus.isConfig        = w_cfg_active;
    assign bus.Data_Config_Out = w_word;

endmodule

// File: tb/tb_cic_cfg_sequencer.sv
// Bench for cic_cfg_sequencer: table vectors, hand-written corner sequences and random requests
// against a per-cycle timeline model derived from the request and the scheduled CIC responses.
module tb_cic_cfg_sequencer;

    localparam int DRAIN = 64;
    localparam int TMO   = 1024;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    cic_cfg_sequencer_if #(.DW(16)) bus ();

    cic_cfg_sequencer #(
        .CIC_CONFIG_DATA_WIDTH (16),
        .CIC_MAX_NUMSECS       (16),
        .CIC_MAX_DCEF          (16),
        .DRAIN_CYCLES          (DRAIN),
        .TIMEOUT_CYCLES        (TMO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] ns;
        logic [15:0] dc;
        logic [15:0] sc;
        int          a;       // cycles a word is shown before ACK
        int          d;       // cycles from last ACK to Done (>=1)
        bit          src_hi;
        bit          rereq;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @t=%0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_err(input logic [15:0] ns, input logic [15:0] dc);
        return (ns >= 1 && ns <= 16 && dc >= 1 && dc <= 16) ? 2'd0 : 2'd1;
    endfunction

    task automatic drive(input logic rq, input logic [15:0] ns, input logic [15:0] dc,
                         input logic [15:0] sc, input logic ack, input logic dn, input logic src);
        bus.Cfg_Req      = rq;
        bus.Cfg_NumSecs  = ns;
        bus.Cfg_Dcef     = dc;
        bus.Cfg_Scale    = sc;
        bus.isConfigACK  = ack;
        bus.isConfigDone = dn;
        bus.Src_Valid    = src;
    endtask

    task automatic drive_idle(input logic src);
        drive(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0, src);
    endtask

    task automatic run_cfg(input vec_t v);
        logic [15:0] w[3];
        logic [1:0]  e_err;
        logic [15:0] e_dat;
        bit ok, gated, cfg, busy, rq, ack, dn;
        logic src;
        int t_done, idx, drop;
        w     = '{v.ns, v.dc, v.sc};
        e_err = ref_err(v.ns, v.dc);
        ok    = (e_err == 2'd0);
        t_done = ok ? DRAIN + 3 * (v.a + 1) + v.d : 1;
        drop  = 0;
        @(posedge CLK); #1;
        drive(1'b1, v.ns, v.dc, v.sc, 1'b0, 1'b0, v.src_hi ? 1'b1 : 1'($urandom));
        for (int t = 1; t <= t_done + 2; t++) begin
            @(posedge CLK); #1;
            rq  = ok && v.rereq && (t == 10);
            ack = ok && (t > DRAIN) && (t <= DRAIN + 3 * (v.a + 1)) && (((t - DRAIN - 1) % (v.a + 1)) == v.a);
            dn  = ok && (t == t_done);
            src = v.src_hi ? 1'b1 : 1'($urandom);
            if (rq) drive(1'b1, ~v.ns, ~v.dc, ~v.sc, ack, dn, src);
            else    drive(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), ack, dn, src);
            gated = ok && (t <= t_done);
            cfg   = ok && (t > DRAIN) && (t <= t_done);
            idx   = cfg ? (t - DRAIN - 1) / (v.a + 1) : 0;
            if (idx > 2) idx = 2;
            e_dat = cfg ? w[idx] : 16'd0;
            busy  = ok ? (t <= t_done) : (t == 1);
            @(negedge CLK);
            chk("gated_valid", t, 32'(bus.Gated_Valid), 32'(src && !gated));
            chk("is_config",   t, 32'(bus.isConfig), 32'(cfg));
            chk("cfg_data",    t, 32'(bus.Data_Config_Out), 32'(e_dat));
            chk("cfg_busy",    t, 32'(bus.Cfg_Busy), 32'(busy));
            chk("cfg_done",    t, 32'(bus.Cfg_Done), 32'(ok && (t == t_done + 1)));
            chk("cfg_err",     t, 32'(bus.Cfg_Err), 32'(e_err));
            chk("drop_cnt",    t, 32'(bus.Drop_Cnt), 32'(drop));
            if (gated && src) drop++;
        end
        chk("final_err", t_done + 2, 32'(bus.Cfg_Err), 32'(v.exp_err));
    endtask

    initial begin
        tbl[0] = '{16'd5,  16'd8,  16'd3, 2, 4, 1'b1, 1'b0, 2'd0};
        tbl[1] = '{16'd0,  16'd8,  16'd3, 0, 1, 1'b1, 1'b0, 2'd1};
        tbl[2] = '{16'd5,  16'd17, 16'd3, 0, 1, 1'b0, 1'b0, 2'd1};
        tbl[3] = '{16'd16, 16'd16, 16'd7, 0, 1, 1'b0, 1'b0, 2'd0};
        tbl[4] = '{16'd1,  16'd1,  16'd0, 1, 2, 1'b0, 1'b0, 2'd0};
        tbl[5] = '{16'd17, 16'd4,  16'd9, 0, 1, 1'b0, 1'b0, 2'd1};
        tbl[6] = '{16'd4,  16'd0,  16'd9, 0, 1, 1'b1, 1'b0, 2'd1};
        tbl[7] = '{16'd9,  16'd2,  16'd6, 1, 3, 1'b1, 1'b1, 2'd0};

        RST = 1'b1;
        drive_idle(1'b1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy",   0, 32'(bus.Cfg_Busy), 32'd0);
        chk("rst_done",   0, 32'(bus.Cfg_Done), 32'd0);
        chk("rst_err",    0, 32'(bus.Cfg_Err), 32'd0);
        chk("rst_drop",   0, 32'(bus.Drop_Cnt), 32'd0);
        chk("rst_cfg",    0, 32'(bus.isConfig), 32'd0);
        chk("rst_data",   0, 32'(bus.Data_Config_Out), 32'd0);
        chk("rst_gvalid", 0, 32'(bus.Gated_Valid), 32'd1);
        RST = 1'b0;

        for (int i = 0; i < 8; i++) run_cfg(tbl[i]);

        // Watchdog: never acknowledge the first word.
        @(posedge CLK); #1;
        drive(1'b1, 16'd5, 16'd8, 16'd3, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= DRAIN + TMO + 2; t++) begin
            @(posedge CLK); #1;
            drive_idle(1'b1);
            @(negedge CLK);
            if (t == DRAIN + TMO) begin
                chk("tmo_pre_cfg", t, 32'(bus.isConfig), 32'd1);
                chk("tmo_pre_err", t, 32'(bus.Cfg_Err), 32'd0);
            end
            if (t == DRAIN + TMO + 1) begin
                chk("tmo_err",    t, 32'(bus.Cfg_Err), 32'd2);
                chk("tmo_cfg",    t, 32'(bus.isConfig), 32'd0);
                chk("tmo_gvalid", t, 32'(bus.Gated_Valid), 32'd1);
                chk("tmo_drop",   t, 32'(bus.Drop_Cnt), 32'(DRAIN + TMO));
            end
            if (t == DRAIN + TMO + 2) begin
                chk("tmo_busy", t, 32'(bus.Cfg_Busy), 32'd0);
                chk("tmo_done", t, 32'(bus.Cfg_Done), 32'd0);
                chk("tmo_sticky", t, 32'(bus.Cfg_Err), 32'd2);
            end
        end

        // Done together with the first ACK while still sending.
        @(posedge CLK); #1;
        drive(1'b1, 16'd3, 16'd4, 16'd5, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= DRAIN + 3; t++) begin
            @(posedge CLK); #1;
            if (t == DRAIN + 1) drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
            else                drive_idle(1'b0);
            @(negedge CLK);
            if (t == DRAIN + 1) chk("proto_word0", t, 32'(bus.Data_Config_Out), 32'd3);
            if (t == DRAIN + 2) begin
                chk("proto_err",  t, 32'(bus.Cfg_Err), 32'd2);
                chk("proto_cfg",  t, 32'(bus.isConfig), 32'd0);
                chk("proto_busy", t, 32'(bus.Cfg_Busy), 32'd1);
            end
            if (t == DRAIN + 3) begin
                chk("proto_idle", t, 32'(bus.Cfg_Busy), 32'd0);
                chk("proto_done", t, 32'(bus.Cfg_Done), 32'd0);
            end
        end

        // Reset pulse one cycle after the first word is acknowledged.
        @(posedge CLK); #1;
        drive(1'b1, 16'd6, 16'd7, 16'd2, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= DRAIN + 3; t++) begin
            @(posedge CLK); #1;
            RST = (t == DRAIN + 2);
            if (t == DRAIN + 1) drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
            else                drive_idle(1'b1);
            @(negedge CLK);
            if (t == DRAIN + 2) chk("rstm_word1", t, 32'(bus.Data_Config_Out), 32'd7);
            if (t == DRAIN + 3) begin
                chk("rstm_cfg",    t, 32'(bus.isConfig), 32'd0);
                chk("rstm_data",   t, 32'(bus.Data_Config_Out), 32'd0);
                chk("rstm_busy",   t, 32'(bus.Cfg_Busy), 32'd0);
                chk("rstm_err",    t, 32'(bus.Cfg_Err), 32'd0);
                chk("rstm_drop",   t, 32'(bus.Drop_Cnt), 32'd0);
                chk("rstm_gvalid", t, 32'(bus.Gated_Valid), 32'd1);
            end
        end
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            vec_t r;
            r.ns      = 16'($urandom_range(0, 18));
            r.dc      = 16'($urandom_range(0, 18));
            r.sc      = 16'($urandom);
            r.a       = int'($urandom_range(0, 3));
            r.d       = int'($urandom_range(1, 5));
            r.src_hi  = 1'($urandom);
            r.rereq   = 1'($urandom);
            r.exp_err = ref_err(r.ns, r.dc);
            run_cfg(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
